multicycle_main_fsm: RTL

Main control state machine for the multi-cycle RV32I core variant. It sequences the shared ALU, memory, instruction register and register file across several cycles per instruction. It drives o_ALUOp into the existing ALU decoder, which keeps producing ALUControl_t. It handles lw, sw, R-type, I-type ALU, beq and jal, and stalls on a memory-ready handshake.

---
 rtl/multicycle_main_fsm_pkg.sv | 55 +++++
 rtl/multicycle_main_fsm_imm_src_decoder.sv | 20 ++
 rtl/multicycle_main_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_main_fsm_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main control FSM.
// Also imported by the opcode-to-immediate decoder.
package MainFSM_pkg;

    localparam int OPCODE_W = 7;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } ALUOp_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } ImmSrc_t;

    // Result / operand mux encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/multicycle_main_fsm_imm_src_decoder.sv
// Combinational opcode -> immediate-format select; shared with the single-cycle core.
module imm_src_decoder
    import MainFSM_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_OpCode,
    output ImmSrc_t             o_ImmSrc
);

    always_comb begin
        case (i_OpCode)
            OP_LW:   o_ImmSrc = IMM_I;
            OP_I:    o_ImmSrc = IMM_I;
            OP_SW:   o_ImmSrc = IMM_S;
            OP_BEQ:  o_ImmSrc = IMM_B;
            OP_JAL:  o_ImmSrc = IMM_J;
            default: o_ImmSrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences PC, IR, memory,
// ALU and register file over several cycles per instruction.
module multicycle_main_fsm
    import MainFSM_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int STATE_W  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [OPCODE_W-1:0] i_OpCode,
    input  logic                i_Zero,
    input  logic                i_MemReady,
    output logic                o_MemReq,
    output logic                o_MemWrite,
    output logic                o_AdrSrc,
    output logic                o_IRWrite,
    output logic                o_PCWrite,
    output logic                o_RegWrite,
    output logic [1:0]          o_ResultSrc,
    output logic [1:0]          o_ALUSrcA,
    output logic [1:0]          o_ALUSrcB,
    output logic [1:0]          o_ALUOp,
    output logic [1:0]          o_ImmSrc,
    output logic                o_Illegal,
    output logic [STATE_W-1:0]  o_State
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_adr_src;
    logic       w_ir_write;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    ALUOp_t     w_alu_op;
    ImmSrc_t    w_imm_src;

    imm_src_decoder u_imm_src_decoder (
        .i_OpCode (i_OpCode),
        .o_ImmSrc (w_imm_src)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == TRAP)
                r_illegal <= 1'b1;
        end
    end

    // Memory handshake: o_MemReq holds the request (address/strobe stable)
    // until the memory answers with i_MemReady=1; that cycle completes the access.
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RD2;
        w_alu_op     = ALUOP_ADD;

        case (r_state)
            FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = i_MemReady;
                w_pc_update  = i_MemReady;
                if (i_MemReady)
                    w_next = DECODE;
            end
            DECODE: begin
                // Precompute PC-relative branch/jump target into ALUOut
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (i_OpCode)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECUTER;
                    OP_I:         w_next = EXECUTEI;
                    OP_BEQ:       w_next = BEQ;
                    OP_JAL:       w_next = JAL;
                    default:      w_next = TRAP;
                endcase
            end
            MEMADR: begin
                w_alu_src_a = SRCA_RD1;
                w_alu_src_b = SRCB_IMM;
                w_next      = (i_OpCode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                w_adr_src = 1'b1;
                w_mem_req = 1'b1;
                if (i_MemReady)
                    w_next = MEMWB;
            end
            MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_next       = FETCH;
            end
            MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                if (i_MemReady)
                    w_next = FETCH;
            end
            EXECUTER: begin
                w_alu_src_a = SRCA_RD1;
                w_alu_src_b = SRCB_RD2;
                w_alu_op    = ALUOP_FUNCT;
                w_next      = ALUWB;
            end
            EXECUTEI: begin
                w_alu_src_a = SRCA_RD1;
                w_alu_src_b = SRCB_IMM;
                w_alu_op    = ALUOP_FUNCT;
                w_next      = ALUWB;
            end
            ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = FETCH;
            end
            BEQ: begin
                w_alu_src_a = SRCA_RD1;
                w_alu_src_b = SRCB_RD2;
                w_alu_op    = ALUOP_SUB;
                w_branch    = 1'b1;
                w_next      = FETCH;
            end
            JAL: begin
                // PC <- target from DECODE; ALU forms PC+4 for the link write
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = ALUWB;
            end
            TRAP: begin
                w_next = TRAP;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // Reset gates every write enable so nothing commits while it is held
    assign o_MemReq    = w_mem_req   & ~i_rst;
    assign o_MemWrite  = w_mem_write & ~i_rst;
    assign o_IRWrite   = w_ir_write  & ~i_rst;
    assign o_RegWrite  = w_reg_write & ~i_rst;
    assign o_PCWrite   = (w_pc_update | (w_branch & i_Zero)) & ~i_rst;
    assign o_AdrSrc    = w_adr_src;
    assign o_ResultSrc = w_result_src;
    assign o_ALUSrcA   = w_alu_src_a;
    assign o_ALUSrcB   = w_alu_src_b;
    assign o_ALUOp     = w_alu_op;
    assign o_ImmSrc    = w_imm_src;
    assign o_Illegal   = r_illegal;
    assign o_State     = STATE_W'(r_state);

endmodule
